// File: rtl/wishbone_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_mem_slave
// Purpose  : Wishbone responder backed by a word-addressed on-chip RAM
//            (16-bit data, 24-bit word address). Single and back-to-back
//            beats, with WAIT_STATES extra cycles inserted before the
//            response.
// Ports    : i_clk, i_rst (async, active-high)
//            wb_cyc, wb_stb, wb_we, wb_adr[23:0], wb_i_dat[15:0], wb_sel[1:0]
//            wb_o_dat[15:0], wb_ack, wb_err, wb_rty (tied 0)
// Options  : WB_SLAVE_ERR_EN - when defined, beats outside
//            [ADDR_BASE, ADDR_BASE + 2**DEPTH_LOG2) complete with wb_err and
//            leave the RAM untouched; otherwise addresses alias.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_mem_slave #(
  parameter logic [23:0] ADDR_BASE   = 24'h000000,
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [23:0] wb_adr,
  input  logic [15:0] wb_i_dat,
  input  logic [1:0]  wb_sel,
  output logic [15:0] wb_o_dat,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_rty
);

  localparam int         c_DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);
  localparam bit         c_NO_WAIT   = (WAIT_STATES == 0);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [3:0]            r_wait_cnt;
  logic                  r_we;
  logic [23:0]           r_adr;
  logic [15:0]           r_dat;
  logic [1:0]            r_sel;
  logic [15:0]           r_rdata;
  logic [15:0]           r_mem [c_DEPTH];

  logic                  w_start;
  logic                  w_commit;
  logic                  w_live;
  logic                  w_we;
  logic [23:0]           w_adr;
  logic [15:0]           w_dat;
  logic [1:0]            w_sel;
  logic [23:0]           w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oor;
  logic                  w_mem_we;

  assign w_start = (r_state == c_ST_IDLE) && wb_cyc && wb_stb;

  // With no wait states the beat is latched and committed on the same edge,
  // so the commit must use the live bus rather than the (not yet loaded)
  // latched copy.
  assign w_live = (r_state == c_ST_IDLE);
  assign w_we   = w_live ? wb_we    : r_we;
  assign w_adr  = w_live ? wb_adr   : r_adr;
  assign w_dat  = w_live ? wb_i_dat : r_dat;
  assign w_sel  = w_live ? wb_sel   : r_sel;

  assign w_commit = (w_start && c_NO_WAIT) ||
                    ((r_state == c_ST_WAIT) && wb_cyc && (r_wait_cnt == 4'd1));

  // 24-bit subtract with wrap; the low bits are the RAM index in both builds.
  assign w_off = w_adr - ADDR_BASE;
  assign w_idx = w_off[DEPTH_LOG2-1:0];

`ifdef WB_SLAVE_ERR_EN
  logic r_err;
  assign w_oor = ((w_off >> DEPTH_LOG2) != 24'd0);
`else
  logic w_unused_off_hi;
  assign w_oor           = 1'b0;
  assign w_unused_off_hi = ^w_off[23:DEPTH_LOG2];
`endif

  // Reset gating keeps a commit edge that coincides with reset from writing.
  assign w_mem_we = w_commit && w_we && !w_oor && !i_rst;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= c_ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: if (w_start) w_state_next = c_NO_WAIT ? c_ST_RESP : c_ST_WAIT;
      c_ST_WAIT: begin
        if (!wb_cyc)                  w_state_next = c_ST_IDLE;  // abort
        else if (r_wait_cnt == 4'd1)  w_state_next = c_ST_RESP;
      end
      c_ST_RESP: w_state_next = c_ST_IDLE;  // strobe ignored here
      default:   w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (r_state == c_ST_RESP) begin
`ifdef WB_SLAVE_ERR_EN
      wb_ack = !r_err;
      wb_err = r_err;
`else
      wb_ack = 1'b1;
`endif
    end
  end

  assign wb_rty   = 1'b0;
  assign wb_o_dat = r_rdata;

  // ----------------------------------------------------------- datapath
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= 4'd0;
      r_we       <= 1'b0;
      r_adr      <= 24'd0;
      r_dat      <= 16'd0;
      r_sel      <= 2'd0;
      r_rdata    <= 16'd0;
`ifdef WB_SLAVE_ERR_EN
      r_err      <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_we       <= wb_we;
        r_adr      <= wb_adr;
        r_dat      <= wb_i_dat;
        r_sel      <= wb_sel;
        r_wait_cnt <= c_WAIT_INIT;
      end else if (r_state == c_ST_WAIT) begin
        r_wait_cnt <= wb_cyc ? (r_wait_cnt - 4'd1) : 4'd0;
      end

      if (w_commit) begin
        // Writes and failed beats return zero; reads return the word.
        r_rdata <= (w_we || w_oor) ? 16'd0 : r_mem[w_idx];
`ifdef WB_SLAVE_ERR_EN
        r_err   <= w_oor;
`endif
      end
    end
  end

  // RAM contents survive reset, so the array lives in its own clocked block.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      if (w_sel[0]) r_mem[w_idx][7:0]  <= w_dat[7:0];
      if (w_sel[1]) r_mem[w_idx][15:8] <= w_dat[15:8];
    end
  end

endmodule
`default_nettype wire
